// File: rtl/cv_divider_arbiter_if.sv
// Bundle of client-side and divider-side signals around the shared divider arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface cv_divider_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32
);
  logic [NREQ-1:0]       cli_req;
  logic [NREQ*WIDTH-1:0] cli_nn;
  logic [NREQ*WIDTH-1:0] cli_dd;
  logic [NREQ-1:0]       cli_gnt;
  logic [NREQ-1:0]       cli_done;
  logic [WIDTH-1:0]      cli_rr;
  logic                  cli_fail;
  logic                  div_req;
  logic [WIDTH-1:0]      div_nn;
  logic [WIDTH-1:0]      div_dd;
  logic                  div_rdy;
  logic [WIDTH-1:0]      div_rr;
  logic                  busy;

  modport slave (
    input  cli_req, cli_nn, cli_dd, div_rdy, div_rr,
    output cli_gnt, cli_done, cli_rr, cli_fail, div_req, div_nn, div_dd, busy
  );

  modport master (
    output cli_req, cli_nn, cli_dd, div_rdy, div_rr,
    input  cli_gnt, cli_done, cli_rr, cli_fail, div_req, div_nn, div_dd, busy
  );
endinterface

// File: rtl/cv_divider_arbiter.sv
// Round-robin arbiter sharing one req/rdy integer divider between NREQ clients,
// with local divide-by-zero handling and a watchdog for a divider that never answers.
module cv_divider_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  cv_divider_arbiter_if.slave  io_bus
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StReturn} state_e;

  state_e            r_state, w_state_d;
  logic [IdxW-1:0]   r_last, w_last_d;
  logic [IdxW-1:0]   r_owner, w_owner_d;
  logic [WIDTH-1:0]  r_nn, w_nn_d;
  logic [WIDTH-1:0]  r_dd, w_dd_d;
  logic              r_stale, w_stale_d;
  logic [15:0]       r_wdog, w_wdog_d;
  logic [NREQ-1:0]   r_gnt, w_gnt_d;
  logic [NREQ-1:0]   r_done, w_done_d;
  logic [WIDTH-1:0]  r_cli_rr, w_cli_rr_d;
  logic              r_cli_fail, w_cli_fail_d;

  logic              w_found;
  logic [IdxW-1:0]   w_win;
  logic [WIDTH-1:0]  w_sel_nn, w_sel_dd;
  logic [WIDTH-1:0]  w_rr;
  logic              w_fail;

  // Round-robin scan starting one past the previous winner.
  always_comb begin : p_rr
    int unsigned idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = 32'(r_last) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && io_bus.cli_req[IdxW'(idx)]) begin
        w_found = 1'b1;
        w_win   = IdxW'(idx);
      end
    end
  end

  assign w_sel_nn = io_bus.cli_nn[32'(w_win) * WIDTH +: WIDTH];
  assign w_sel_dd = io_bus.cli_dd[32'(w_win) * WIDTH +: WIDTH];

  always_comb begin : p_next
    w_state_d    = r_state;
    w_last_d     = r_last;
    w_owner_d    = r_owner;
    w_nn_d       = r_nn;
    w_dd_d       = r_dd;
    w_stale_d    = r_stale;
    w_wdog_d     = r_wdog;
    w_gnt_d      = '0;
    w_done_d     = '0;
    w_cli_rr_d   = '0;
    w_cli_fail_d = 1'b0;
    w_rr         = '0;
    w_fail       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.div_rdy) w_stale_d = 1'b0;
        if (w_found) begin
          w_nn_d          = w_sel_nn;
          w_dd_d          = w_sel_dd;
          w_owner_d       = w_win;
          w_last_d        = w_win;
          w_gnt_d[w_win]  = 1'b1;
          if (w_sel_dd == '0) begin
            w_rr      = '1;
            w_fail    = 1'b1;
            w_state_d = StReturn;
          end else begin
            w_state_d = StIssue;
          end
        end
      end
      StIssue: begin
        w_wdog_d  = 16'(TIMEOUT);
        w_state_d = StWait;
      end
      StWait: begin
        if (io_bus.div_rdy && !r_stale) begin
          w_rr      = io_bus.div_rr;
          w_fail    = 1'b0;
          w_state_d = StReturn;
        end else begin
          // A rdy while stale belongs to the abandoned operation: drop it, keep counting.
          if (io_bus.div_rdy) w_stale_d = 1'b0;
          w_wdog_d = r_wdog - 16'd1;
          if (r_wdog <= 16'd1) begin
            w_rr      = '0;
            w_fail    = 1'b1;
            w_stale_d = 1'b1;
            w_state_d = StReturn;
          end
        end
      end
      StReturn: begin
        if (io_bus.div_rdy) w_stale_d = 1'b0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // Result outputs are registered on entry to RETURN so they line up with the state.
    if (w_state_d == StReturn) begin
      w_done_d[w_owner_d] = 1'b1;
      w_cli_rr_d          = w_rr;
      w_cli_fail_d        = w_fail;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_last     <= IdxW'(NREQ - 1);
      r_owner    <= '0;
      r_nn       <= '0;
      r_dd       <= '0;
      r_stale    <= 1'b0;
      r_wdog     <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_cli_rr   <= '0;
      r_cli_fail <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_last     <= w_last_d;
      r_owner    <= w_owner_d;
      r_nn       <= w_nn_d;
      r_dd       <= w_dd_d;
      r_stale    <= w_stale_d;
      r_wdog     <= w_wdog_d;
      r_gnt      <= w_gnt_d;
      r_done     <= w_done_d;
      r_cli_rr   <= w_cli_rr_d;
      r_cli_fail <= w_cli_fail_d;
    end
  end

  assign io_bus.cli_gnt  = r_gnt;
  assign io_bus.cli_done = r_done;
  assign io_bus.cli_rr   = r_cli_rr;
  assign io_bus.cli_fail = r_cli_fail;
  assign io_bus.div_req  = (r_state == StIssue);
  assign io_bus.div_nn   = r_nn;
  assign io_bus.div_dd   = r_dd;
  assign io_bus.busy     = (r_state != StIdle);

endmodule

// File: tb/tb_cv_divider_arbiter.sv
// Scoreboard bench for cv_divider_arbiter: directed operations push expected grants and
// results; a negedge monitor pops and compares whenever the DUT pulses gnt/done.
module tb_cv_divider_arbiter;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMEOUT = 8;

  typedef struct {
    int               client;
    logic [WIDTH-1:0] rr;
    logic             fail;
  } exp_t;

  typedef struct {
    int               cnt;
    logic [WIDTH-1:0] q;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cv_divider_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  cv_divider_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (clk),
    .i_reset(reset_n),
    .io_bus (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   gnt_cyc = -1;
  int   done_cyc = -1;
  int   req_cyc = -1;
  int   n_div_req = 0;
  exp_t exp_done_q[$];
  int   exp_gnt_q[$];
  exp_t mon_x;
  int   mon_g;

  ev_t  ev_q[$];
  int   div_lat = 5;
  bit   mute_next = 1'b0;
  int   stuck_lat = 14;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no event required one within bound", name);
  endtask

  // Divider model: answers div_req after div_lat cycles, or much later with junk when muted.
  always @(negedge clk) begin
    bus.div_rdy = 1'b0;
    bus.div_rr  = '0;
    foreach (ev_q[i]) ev_q[i].cnt--;
    if (ev_q.size() > 0 && ev_q[0].cnt <= 0) begin
      bus.div_rdy = 1'b1;
      bus.div_rr  = ev_q[0].q;
      void'(ev_q.pop_front());
    end
    if (bus.div_req === 1'b1) begin
      n_div_req++;
      req_cyc = cyc;
      if (mute_next) begin
        ev_q.push_back('{stuck_lat, 32'hDEADBEEF});
        mute_next = 1'b0;
      end else begin
        ev_q.push_back('{div_lat, bus.div_nn / bus.div_dd});
      end
    end
  end

  // Monitor: compares every grant and result pulse against the scoreboard queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.cli_gnt != '0) begin
        gnt_cyc = cyc;
        if (exp_gnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_gnt: got 0x%0h required none", bus.cli_gnt);
        end else begin
          mon_g = exp_gnt_q.pop_front();
          check("gnt_onehot", 64'(bus.cli_gnt), 64'(1) << mon_g);
        end
      end
      if (bus.cli_done != '0) begin
        done_cyc = cyc;
        if (exp_done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got 0x%0h required none", bus.cli_done);
        end else begin
          mon_x = exp_done_q.pop_front();
          check("done_onehot", 64'(bus.cli_done), 64'(1) << mon_x.client);
          check("done_rr", 64'(bus.cli_rr), 64'(mon_x.rr));
          check("done_fail", 64'(bus.cli_fail), 64'(mon_x.fail));
        end
      end else begin
        check("rr_idle_zero", 64'(bus.cli_rr), 64'd0);
      end
    end
  end

  task automatic set_ops(input int c, input logic [WIDTH-1:0] nn, input logic [WIDTH-1:0] dd);
    bus.cli_nn[c*WIDTH +: WIDTH] = nn;
    bus.cli_dd[c*WIDTH +: WIDTH] = dd;
  endtask

  task automatic wait_gnt(input int c);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = bus.cli_gnt[c];
    end
    if (!seen) fail_now($sformatf("gnt_timeout_c%0d", c));
  endtask

  task automatic wait_done(input int c, output int t);
    bit seen = 1'b0;
    t = -1;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = bus.cli_done[c];
      if (seen) t = cyc;
    end
    if (!seen) fail_now($sformatf("done_timeout_c%0d", c));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = !bus.busy && exp_done_q.size() == 0;
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 64'(bus.cli_gnt), 64'd0);
    check({tag, "_done"}, 64'(bus.cli_done), 64'd0);
    check({tag, "_rr"}, 64'(bus.cli_rr), 64'd0);
    check({tag, "_fail"}, 64'(bus.cli_fail), 64'd0);
    check({tag, "_div_req"}, 64'(bus.div_req), 64'd0);
    check({tag, "_div_nn"}, 64'(bus.div_nn), 64'd0);
    check({tag, "_div_dd"}, 64'(bus.div_dd), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no summary required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int ta, td, ngnt, n0;
    bus.cli_req = '0;
    bus.cli_nn  = '0;
    bus.cli_dd  = '0;
    bus.div_rdy = 1'b0;
    bus.div_rr  = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single client 1, latency 5: gnt/div_req at C1, done at C7.
    div_lat = 5;
    set_ops(1, 32'd1000000000, 32'd3);
    exp_gnt_q.push_back(1);
    exp_done_q.push_back('{1, 32'd333333333, 1'b0});
    bus.cli_req[1] = 1'b1;
    wait_gnt(1);
    bus.cli_req[1] = 1'b0;
    wait_idle();
    check("t1_req_with_gnt", 64'(req_cyc), 64'(gnt_cyc));
    check("t1_done_latency", 64'(done_cyc - gnt_cyc), 64'd6);

    // Zero divisor on client 2: gnt and done together, no divider pass.
    n0 = n_div_req;
    set_ops(2, 32'd77, 32'd0);
    exp_gnt_q.push_back(2);
    exp_done_q.push_back('{2, 32'hFFFFFFFF, 1'b1});
    bus.cli_req[2] = 1'b1;
    wait_gnt(2);
    bus.cli_req[2] = 1'b0;
    wait_idle();
    check("zero_same_cycle", 64'(done_cyc), 64'(gnt_cyc));
    check("zero_no_div_req", 64'(n_div_req - n0), 64'd0);

    // All four clients hammering: order 0,1,2,3,0,1 after reset.
    do_reset();
    set_ops(0, 32'd100, 32'd7);
    set_ops(1, 32'd1000, 32'd10);
    set_ops(2, 32'd65535, 32'd256);
    set_ops(3, 32'hFFFFFFFF, 32'd16);
    foreach (exp_gnt_q[i]) ;
    for (int k = 0; k < 6; k++) exp_gnt_q.push_back(k % 4);
    exp_done_q.push_back('{0, 32'd14, 1'b0});
    exp_done_q.push_back('{1, 32'd100, 1'b0});
    exp_done_q.push_back('{2, 32'd255, 1'b0});
    exp_done_q.push_back('{3, 32'h0FFFFFFF, 1'b0});
    exp_done_q.push_back('{0, 32'd14, 1'b0});
    exp_done_q.push_back('{1, 32'd100, 1'b0});
    bus.cli_req = '1;
    ngnt = 0;
    for (int n = 0; n < 400 && ngnt < 6; n++) begin
      @(negedge clk);
      for (int c = 0; c < int'(NREQ); c++) begin
        if (bus.cli_gnt[c]) begin
          bus.cli_req[c] = 1'b0;
          ngnt++;
        end
        if (bus.cli_done[c]) bus.cli_req[c] = 1'b1;
      end
    end
    bus.cli_req = '0;
    if (ngnt < 6) fail_now("rr_grants");
    wait_idle();

    // Timeout on client 0, then its stale rdy lands inside client 2's WAIT.
    set_ops(0, 32'd50, 32'd5);
    set_ops(2, 32'd81, 32'd9);
    exp_gnt_q.push_back(0);
    exp_done_q.push_back('{0, 32'd0, 1'b1});
    exp_gnt_q.push_back(2);
    exp_done_q.push_back('{2, 32'd9, 1'b0});
    mute_next = 1'b1;
    bus.cli_req[0] = 1'b1;
    wait_gnt(0);
    ta = cyc;
    bus.cli_req[0] = 1'b0;
    bus.cli_req[2] = 1'b1;
    wait_done(0, td);
    check("timeout_latency", 64'(td - ta), 64'(TIMEOUT + 1));
    wait_gnt(2);
    bus.cli_req[2] = 1'b0;
    wait_idle();
    check("stale_discard_latency", 64'(done_cyc - gnt_cyc), 64'd6);

    // rdy on the cycle the watchdog expires: rdy wins and stale stays clear.
    div_lat = TIMEOUT;
    set_ops(3, 32'd1000000, 32'd1000);
    exp_gnt_q.push_back(3);
    exp_done_q.push_back('{3, 32'd1000, 1'b0});
    bus.cli_req[3] = 1'b1;
    wait_gnt(3);
    ta = cyc;
    bus.cli_req[3] = 1'b0;
    wait_done(3, td);
    check("coincide_latency", 64'(td - ta), 64'(TIMEOUT + 1));
    wait_idle();
    div_lat = 5;
    set_ops(1, 32'd144, 32'd12);
    exp_gnt_q.push_back(1);
    exp_done_q.push_back('{1, 32'd12, 1'b0});
    bus.cli_req[1] = 1'b1;
    wait_gnt(1);
    bus.cli_req[1] = 1'b0;
    wait_idle();
    check("post_coincide_latency", 64'(done_cyc - gnt_cyc), 64'd6);

    // Reset in WAIT: outputs clear at once, no done, client 0 then wins over 3.
    set_ops(3, 32'd900, 32'd30);
    exp_gnt_q.push_back(3);
    bus.cli_req[3] = 1'b1;
    wait_gnt(3);
    bus.cli_req[3] = 1'b0;
    repeat (2) @(negedge clk);
    check("midop_busy_before", 64'(bus.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check_zero("midop_reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    set_ops(0, 32'd10, 32'd2);
    set_ops(3, 32'd900, 32'd30);
    exp_gnt_q.push_back(0);
    exp_gnt_q.push_back(3);
    exp_done_q.push_back('{0, 32'd5, 1'b0});
    exp_done_q.push_back('{3, 32'd30, 1'b0});
    bus.cli_req[0] = 1'b1;
    bus.cli_req[3] = 1'b1;
    wait_gnt(0);
    bus.cli_req[0] = 1'b0;
    wait_gnt(3);
    bus.cli_req[3] = 1'b0;
    wait_idle();
    check("gnt_queue_drained", 64'(exp_gnt_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cv_divider_arbiter.md
# cv_divider_arbiter

Shares one request/ready integer divider unit (CV_INT_FL_DIVIDER_US-style: `req` pulse with `NN`/`DD`, later `rdy` pulse with `RR`) between `NREQ` independent clients. It sequences the divider and arbitrates round-robin between clients. Divide-by-zero is handled locally, without a divider pass. A watchdog recovers from a divider that never answers. It sits between HLS-generated client datapaths and a single divider instance.

## Interface

Parameters:
- `NREQ`, 4: number of clients (2..16).
- `WIDTH`, 32: operand and result width.
- `TIMEOUT`, 255: maximum cycles in WAIT before abort (1..65535).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `cli_req`  in  NREQ  per-client request; held high until the matching `cli_gnt`.
- `cli_nn`  in  NREQ*WIDTH  dividends; client i occupies bits [i*WIDTH +: WIDTH].
- `cli_dd`  in  NREQ*WIDTH  divisors; same packing as `cli_nn`.
- `cli_gnt`  out  NREQ  one-cycle pulse: client's operands have been captured.
- `cli_done`  out  NREQ  one-cycle pulse: result for that client is valid.
- `cli_rr`  out  WIDTH  shared result bus; valid only while a `cli_done` bit is high.
- `cli_fail`  out  1  valid with `cli_done`: 1 means divide-by-zero or timeout.
- `div_req`  out  1  one-cycle start pulse to the divider.
- `div_nn`, `div_dd`  out  WIDTH  captured operands, stable from ISSUE until the controller returns to IDLE.
- `div_rdy`  in  1  divider completion pulse.
- `div_rr`  in  WIDTH  divider result, valid with `div_rdy`.
- `busy`  out  1  high whenever state is not IDLE.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RETURN.
- **IDLE**
  - If any `cli_req` bit is high, pick the winner `w` by round-robin. The scan starts at `last+1` mod `NREQ`.
  - Capture `cli_nn[w]` and `cli_dd[w]` into `div_nn`/`div_dd`. Set `owner=w` and `last=w`. Register a `cli_gnt[w]` pulse for the next cycle.
  - If the captured divisor is 0: next state RETURN, with `rr=all ones` and `fail=1`. Otherwise next state ISSUE.
- **ISSUE**
  - `div_req=1` for this cycle only. Load the watchdog with `TIMEOUT`. Next state WAIT.
  - `div_rdy` is ignored in this state.
- **WAIT**
  - On `div_rdy`: latch `div_rr`, set `fail=0`, go to RETURN.
  - Otherwise the watchdog decrements. If it reaches 0: set `rr=0`, `fail=1`, set sticky `stale`, go to RETURN.
  - If `div_rdy` and watchdog expiry coincide, `div_rdy` wins.
- **RETURN**
  - `cli_done[owner]=1`, `cli_rr=rr`, `cli_fail=fail` for this cycle. Next state IDLE.
- **Stale answer handling**
  - While `stale=1`, the first `div_rdy` seen in WAIT is discarded, `stale` clears, and the controller keeps waiting.
  - The watchdog is not reloaded at that point.
  - A `div_rdy` seen in IDLE or RETURN also clears `stale`.
- `cli_done`, `cli_rr` and `cli_fail` are registered outputs. `cli_rr` is 0 when no `cli_done` bit is high.
- Clients must drop `cli_req` no later than the cycle after their `cli_gnt`. A request still high at the next IDLE is treated as a new operation.
- Results are unsigned quotients, passed through from `div_rr` unmodified.

## Timing

- Reset, asynchronous, active-low:
  - state=IDLE; `last=NREQ-1`, so client 0 has first priority.
  - All outputs 0: `cli_gnt`, `cli_done`, `cli_rr`, `cli_fail`, `div_req`, `div_nn`, `div_dd`, `busy`.
  - `stale=0`, watchdog=0.
- Reset asserted mid-operation: the operation is abandoned with no `cli_done`. A divider `rdy` arriving after reset is released lands in IDLE and is ignored.
- Normal operation, request seen in IDLE at edge E0:
  - C1: `cli_gnt` and `div_req` high (state ISSUE).
  - `div_rdy` sampled at edge Ek (k≥2) → `cli_done` high in cycle Ck+1.
  - IDLE again at Ck+2.
  - Turnaround is divider latency + 3 cycles.
- Zero divisor: C1 has `cli_gnt`, `cli_done`, `cli_fail` and `cli_rr=all ones` together. IDLE at C2.
- Timeout: `cli_done` with `cli_fail=1` occurs `TIMEOUT+1` cycles after `div_req`.
- Only one operation is outstanding at a time. No queueing beyond the clients' held requests.

## Test plan

- Single client 1, `NN=1000000000`, `DD=3`, divider model latency 5 → `cli_gnt[1]` at C1, `div_req` at C1, `cli_done[1]` at C7 with `cli_rr=333333333`, `cli_fail=0`.
- All 4 clients request continuously, reassert after each `done` → grant order 0,1,2,3,0,1; each client's `cli_rr` matches its own operands.
- Client 2, `DD=0` → `cli_gnt[2]` and `cli_done[2]` both at C1 with `cli_rr=0xFFFFFFFF`, `cli_fail=1`; `div_req` never asserted.
- `TIMEOUT=8`, divider never answers → `cli_done` with `cli_fail=1`, `cli_rr=0`, 9 cycles after `div_req`. The stuck `rdy` then arrives during the next operation's WAIT: it is discarded, and the true `rdy` returns the correct quotient.
- `div_rdy` in the same cycle the watchdog reaches 0 → `cli_fail=0`, `cli_rr=div_rr`, `stale` stays 0.
- `reset` pulsed low in WAIT → all outputs 0 immediately. No `cli_done` for the abandoned operation. After release, client 0 wins a simultaneous 0/3 request.
